// File: rtl/mem_responder_if.sv
//------------------------------------------------------------------------------
// mem_responder_if : request/response handshake bundle for mem_responder
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// mem_responder : byte-addressed little-endian memory with fixed-latency response.
// Optional MEM_ERR_EN macro enables size/alignment/range error reporting.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_wait     = 2'd1;
  localparam logic [1:0] c_resp     = 2'd2;
  localparam logic [3:0] c_cnt_last = 4'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [2**ADDR_W];

  logic              w_commit;
  logic              w_err;
  logic              w_word;
  logic              w_half;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_idx [4];
  logic [3:0]        w_lane_en;
  logic [31:0]       w_rdata;

  assign bus.req_ready = (r_state == c_idle);
  assign bus.rsp_valid = (r_state == c_resp);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  assign w_commit = (r_state == c_wait) && (r_cnt == c_cnt_last);

`ifdef MEM_ERR_EN
  assign w_err  = (r_size == 2'd3)
               || ((r_size == 2'd1) && r_addr[0])
               || ((r_size == 2'd2) && (r_addr[1:0] != 2'b00))
               || (r_addr[31:ADDR_W] != '0);
  assign w_word = (r_size == 2'd2);
  assign w_half = (r_size == 2'd1);
  assign w_base = r_addr[ADDR_W-1:0];
`else
  // Size 3 behaves as a word; the address is forced onto the access alignment.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = |r_addr[31:ADDR_W];
  assign w_err  = 1'b0;
  assign w_word = r_size[1];
  assign w_half = (r_size == 2'd1);
  assign w_base = {r_addr[ADDR_W-1:2],
                   (w_word ? 1'b0 : r_addr[1]),
                   ((w_word || w_half) ? 1'b0 : r_addr[0])};
`endif

  assign w_lane_en = w_word ? 4'hF : (w_half ? 4'h3 : 4'h1);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_idx[i] = w_base + ADDR_W'(i);
    end
  end

  assign w_rdata = w_word ? {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]}
                 : w_half ? {16'h0000, r_mem[w_idx[1]], r_mem[w_idx[0]]}
                 :          {24'h000000, r_mem[w_idx[0]]};

  // Storage is never reset; a commit coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          r_mem[w_idx[i]] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'd0;
            r_state <= c_wait;
          end
        end
        c_wait: begin
          if (w_commit) begin
            r_rdata <= (r_we || w_err) ? 32'd0 : w_rdata;
            r_err   <= w_err;
            r_state <= c_resp;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_resp: begin
          if (bus.rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// tb_mem_responder : directed self-checking bench for mem_responder (ADDR_W=12, LATENCY=2)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.ADDR_W(12), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] rd;
  logic        er;
  int          lt;

  // One full transaction; lat = edges from accept to rsp_valid, 99 on timeout.
  task automatic transact(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
    lat   = 99;
    rdata = 'x;
    err   = 1'bx;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_size  = 2'd3;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = ~wdata;
    for (int k = 0; k <= 20; k++) begin
      if (bus.rsp_valid) begin
        lat   = k;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (lat != 99) @(posedge clk);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); else n_pass++;
    n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); else n_pass++;
    n_total++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    transact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, er, lt);
    n_total++; if (lt !== 2) $display("FAIL wr_latency got=%0d exp=2", lt); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL wr_err got=%b exp=0", er); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL wr_rdata got=%h exp=0", rd); else n_pass++;
    transact(1'b0, 2'd2, 32'h10, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_word got=%h exp=deadbeef", rd); else n_pass++;
    n_total++; if (lt !== 2) $display("FAIL rd_latency got=%0d exp=2", lt); else n_pass++;
    transact(1'b0, 2'd0, 32'h11, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h000000BE) $display("FAIL rd_byte got=%h exp=000000be", rd); else n_pass++;
    transact(1'b0, 2'd1, 32'h12, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h0000DEAD) $display("FAIL rd_half got=%h exp=0000dead", rd); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    transact(1'b1, 2'd0, 32'h13, 32'hAAAAAA55, rd, er, lt);
    transact(1'b0, 2'd2, 32'h10, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h55ADBEEF) $display("FAIL byte_lane got=%h exp=55adbeef", rd); else n_pass++;
    transact(1'b1, 2'd2, 32'h14, 32'h00000000, rd, er, lt);
    transact(1'b1, 2'd1, 32'h16, 32'hFFFF1234, rd, er, lt);
    transact(1'b0, 2'd2, 32'h14, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h12340000) $display("FAIL half_lane got=%h exp=12340000", rd); else n_pass++;
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.req_size  = 2'd0;
    for (k = 0; k < 20 && !bus.rsp_valid; k++) @(negedge clk);
    n_total++; if (k !== 2) $display("FAIL bp_latency got=%0d exp=2", k); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid_hold got=%b exp=1", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_rdata !== 32'h55ADBEEF) $display("FAIL bp_rdata_hold got=%h exp=55adbeef", bus.rsp_rdata); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready got=%b exp=0", bus.req_ready); else n_pass++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_after_hs_valid got=%b exp=0", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL bp_no_bypass got=%b exp=1", bus.req_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (k = 0; k < 20 && !bus.rsp_valid; k++) @(negedge clk);
    n_total++; if (k !== 2) $display("FAIL bp_second_latency got=%0d exp=2", k); else n_pass++;
    n_total++; if (bus.rsp_rdata !== 32'h000000EF) $display("FAIL bp_second_rdata got=%h exp=000000ef", bus.rsp_rdata); else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic saw_rsp;
    transact(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, rd, er, lt);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL rstmid_req_ready got=%b exp=1", bus.req_ready); else n_pass++;
    saw_rsp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
      @(negedge clk);
    end
    n_total++; if (saw_rsp !== 1'b0) $display("FAIL rstmid_no_response got=%b exp=0", saw_rsp); else n_pass++;
    transact(1'b0, 2'd2, 32'h20, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL rstmid_contents got=%h exp=cafef00d", rd); else n_pass++;
  endtask

  task automatic test_config();
    transact(1'b1, 2'd2, 32'h0, 32'h0BADC0DE, rd, er, lt);
`ifdef MEM_ERR_EN
    transact(1'b0, 2'd2, 32'h02, 32'd0, rd, er, lt);
    n_total++; if (er !== 1'b1) $display("FAIL err_misaligned got=%b exp=1", er); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL err_misaligned_rdata got=%h exp=0", rd); else n_pass++;
    n_total++; if (lt !== 2) $display("FAIL err_latency got=%0d exp=2", lt); else n_pass++;
    transact(1'b1, 2'd2, 32'h1000, 32'hFFFFFFFF, rd, er, lt);
    n_total++; if (er !== 1'b1) $display("FAIL err_range got=%b exp=1", er); else n_pass++;
    transact(1'b0, 2'd1, 32'h01, 32'd0, rd, er, lt);
    n_total++; if (er !== 1'b1) $display("FAIL err_half_odd got=%b exp=1", er); else n_pass++;
    transact(1'b0, 2'd3, 32'h00, 32'd0, rd, er, lt);
    n_total++; if (er !== 1'b1) $display("FAIL err_size3 got=%b exp=1", er); else n_pass++;
    transact(1'b0, 2'd2, 32'h00, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h0BADC0DE) $display("FAIL err_no_write got=%h exp=0badc0de", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL err_clean_read got=%b exp=0", er); else n_pass++;
`else
    transact(1'b0, 2'd2, 32'h02, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h0BADC0DE) $display("FAIL align_word got=%h exp=0badc0de", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL align_err got=%b exp=0", er); else n_pass++;
    transact(1'b1, 2'd2, 32'h1000, 32'h11223344, rd, er, lt);
    n_total++; if (er !== 1'b0) $display("FAIL wrap_err got=%b exp=0", er); else n_pass++;
    transact(1'b0, 2'd2, 32'h000, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h11223344) $display("FAIL wrap_alias got=%h exp=11223344", rd); else n_pass++;
    transact(1'b0, 2'd3, 32'h000, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h11223344) $display("FAIL size3_word got=%h exp=11223344", rd); else n_pass++;
    transact(1'b0, 2'd1, 32'h003, 32'd0, rd, er, lt);
    n_total++; if (rd !== 32'h00001122) $display("FAIL align_half got=%h exp=00001122", rd); else n_pass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_reset_mid();
    test_config();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
